pipe_mdu: RTL
=============

Name: pipe_mdu

Overview:
- Iterative multiply/divide unit with HI/LO registers for the EX stage of the 5-stage pipeline.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support, which the single-cycle ALU path lacks.
- Parametrised in datapath width.
- Asserts busy while iterating; the hazard unit converts busy into PC/IF_ID hold and an ID_EX bubble.

Parameters:
- XLEN, 32, operand/HI/LO width; must be >= 4. Iteration counter width is $clog2(XLEN)+1 (derived, not a parameter).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  launch operation selected by op (from ID_EX)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  XLEN  operand A (forwarded rs value; dividend)
- b  input  XLEN  operand B (forwarded rt value; divisor)
- flush  input  1  abort in-flight operation (squashed instruction)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  XLEN  data for mthi/mtlo
- busy  output  1  operation in progress; pipeline must stall
- done  output  1  one-cycle pulse: result just written to HI/LO
- hi  output  XLEN  HI register (product upper half / remainder)
- lo  output  XLEN  LO register (product lower half / quotient)

Behaviour:
- Reset (rst=0, asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and shadow registers cleared.
- States: IDLE, RUN, FIX. busy = (state==RUN) | (state==FIX), decoded from registered state only.
- IDLE, start=1, flush=0, sampled at edge E0:
  - Latch |a| and |b| (signed ops: two's-complement magnitude; unsigned: raw).
  - Latch sign_q = a[XLEN-1]^b[XLEN-1] and sign_r = a[XLEN-1], both forced 0 for unsigned ops.
  - Latch op class; counter=XLEN; go RUN.
- RUN: one radix-2 step per edge (E1..E_XLEN); go FIX when counter reaches 0.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, producing a XLEN-bit quotient and XLEN-bit remainder.
- FIX, edge E_{XLEN+1}: write results, go IDLE, done=1 for exactly the following cycle.
  - Multiply: {hi,lo} = sign_q ? -product : product.
  - Divide: lo = sign_q ? -quot : quot; hi = sign_r ? -rem : rem.
- Timing:
  - busy is high for exactly XLEN+1 cycles.
  - done and the new hi/lo are visible together in the cycle after busy falls (33 cycles after the start sample for XLEN=32).
- Divide by zero: no exception; completes with the normal latency. lo = all ones; hi = a (unsigned magnitude restored with sign, i.e. hi = original a). Holds for both signed and unsigned.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- start while busy: ignored.
- start in the done cycle: accepted; done still deasserts next cycle.
- flush while busy: next edge → IDLE, no hi/lo write, no done.
- flush together with start in IDLE: start ignored.
- mthi/mtlo:
  - In IDLE: write hi/lo at the next edge, no done.
  - While busy: ignored.
  - Same cycle as an accepted start: both take effect; the later result overwrites.
- hi/lo change only on reset, mthi/mtlo, or FIX.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF → busy 33 cycles, then done=1 with hi=FFFFFFFE, lo=00000001.
- MULT a=FFFFFFFD (-3) b=00000005 → hi=FFFFFFFF, lo=FFFFFFF1. Then DIV a=FFFFFFF9 (-7) b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00001234 b=0 → lo=FFFFFFFF, hi=00001234. DIV a=80000000 b=FFFFFFFF → lo=80000000, hi=00000000.
- Start DIVU, pulse flush at iteration 10 → busy=0 next cycle, done never asserts, hi/lo keep the prior mtlo value 0000ABCD. A start pulsed during RUN is ignored.
- Assert rst=0 asynchronously mid-RUN → hi=lo=0, busy=done=0 immediately. After rst=1, start MULTU 3×4 → lo=0000000C.
- mtlo wdata=55 in IDLE → lo=00000055 next cycle, done=0. mthi during busy → hi unchanged. Back-to-back start in the done cycle → second op completes 33 cycles later.

Source files
------------

// File: rtl/pipe_mdu_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// The master drives operations and HI/LO moves; the slave reports status and results.
interface pipe_mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/pipe_mdu.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the EX stage.
// Signed ops run on magnitudes; signs are re-applied in the single FIX cycle.
module pipe_mdu #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg;
  logic              is_div_reg, sign_q_reg, sign_r_reg, done_reg;

  logic              is_signed, accept;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_upper, div_trial;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quot, rem, div_lo, div_hi;

  always_comb begin
    is_signed = ~bus.op[0];
    accept    = (state_reg == IDLE) && bus.start && !bus.flush;
    mag_a     = (is_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
    mag_b     = (is_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

    // Multiply: low half holds the unconsumed multiplier bits, product grows from the top.
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_reg[XLEN-1:1]};

    // Divide: remainder in the upper half, quotient bits shift in at the bottom.
    div_upper = acc_reg[2*XLEN-1:XLEN-1];
    div_trial = div_upper - {1'b0, opnd_reg};
    div_ok    = ~div_trial[XLEN];
    div_next  = {div_ok ? div_trial[XLEN-1:0] : div_upper[XLEN-1:0], acc_reg[XLEN-2:0], div_ok};

    prod_fix  = sign_q_reg ? -acc_reg : acc_reg;
    quot      = acc_reg[XLEN-1:0];
    rem       = acc_reg[2*XLEN-1:XLEN];
    // A zero divisor yields an all-ones quotient; the remainder already carries |a|.
    div_lo    = (opnd_reg == '0) ? {XLEN{1'b1}} : (sign_q_reg ? -quot : quot);
    div_hi    = sign_r_reg ? -rem : rem;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (bus.flush) state_next = IDLE;
               else if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.mthi) hi_reg <= bus.wdata;
          if (bus.mtlo) lo_reg <= bus.wdata;
          if (accept) begin
            acc_reg    <= {{XLEN{1'b0}}, mag_a};
            opnd_reg   <= mag_b;
            is_div_reg <= bus.op[1];
            sign_q_reg <= is_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            sign_r_reg <= is_signed & bus.a[XLEN-1];
            cnt_reg    <= CW'(XLEN);
          end
        end
        RUN: begin
          if (!bus.flush) begin
            acc_reg <= is_div_reg ? div_next : mul_next;
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        FIX: begin
          if (!bus.flush) begin
            if (is_div_reg) begin
              hi_reg <= div_hi;
              lo_reg <= div_lo;
            end else begin
              {hi_reg, lo_reg} <= prod_fix;
            end
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == RUN) || (state_reg == FIX);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule
